riscv_ctrl: RTL and testbench

RISCV_CTRL -- requirements
Module: riscv_ctrl

---
 rtl/riscv_ctrl.sv | 155 +++++++++++++++
 tb/tb_riscv_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/riscv_ctrl.sv
// Multi-cycle RISC-V control unit: sequences fetch/decode/exec/mem/writeback
// and raises a sticky trap on an illegal instruction, a memory timeout or a misaligned branch.
module riscv_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        invalid_i,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        inst_req,
  output logic        ir_en,
  output logic        data_req,
  output logic        data_we,
  output logic        reg_write_en,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CAUSE_W = 2;

  localparam logic [CAUSE_W-1:0] CAUSE_NONE     = CAUSE_W'(0);
  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL  = CAUSE_W'(1);
  localparam logic [CAUSE_W-1:0] CAUSE_TIMEOUT  = CAUSE_W'(2);
  localparam logic [CAUSE_W-1:0] CAUSE_MISALIGN = CAUSE_W'(3);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  state_e               state_q, state_d;
  logic [XLEN-1:0]      pc_q, instret_q;
  logic [CNT_W-1:0]     wait_cnt_q;
  logic [CAUSE_W-1:0]   trap_cause_q, trap_cause_d;
  logic                 trap_q;
  logic                 retire_req, retire_ok, wait_clr, wait_inc;
  logic                 wait_hit, retire_bad;

  assign wait_hit   = (wait_cnt_q + CNT_W'(1)) == TIMEOUT;
  assign retire_bad = branch_taken & (branch_target[1:0] != 2'b00);

  // Next-state decode; retire is resolved last so a misaligned target overrides it.
  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    retire_req   = 1'b0;
    retire_ok    = 1'b0;
    wait_clr     = 1'b0;
    wait_inc     = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_hit) begin
          state_d      = S_TRAP;
          trap_cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        if (invalid_i) begin
          state_d      = S_TRAP;
          trap_cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_load | is_store) begin
          state_d  = S_MEM;
          wait_clr = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_store) retire_req = 1'b1;
          else          state_d    = S_WB;
        end else if (wait_hit) begin
          state_d      = S_TRAP;
          trap_cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB:    retire_req = 1'b1;
      S_TRAP:  state_d    = S_TRAP;
      default: begin
        state_d  = S_FETCH;
        wait_clr = 1'b1;
      end
    endcase
    if (retire_req) begin
      if (retire_bad) begin
        state_d      = S_TRAP;
        trap_cause_d = CAUSE_MISALIGN;
      end else begin
        retire_ok = 1'b1;
        state_d   = S_FETCH;
        wait_clr  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      instret_q    <= '0;
      wait_cnt_q   <= '0;
      trap_q       <= 1'b0;
      trap_cause_q <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      trap_cause_q <= trap_cause_d;
      trap_q       <= (state_d == S_TRAP);
      if (retire_ok) begin
        pc_q      <= branch_taken ? branch_target : pc_q + XLEN'(4);
        instret_q <= instret_q + XLEN'(1);
      end
      if (wait_clr)      wait_cnt_q <= '0;
      else if (wait_inc) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end
  end

  // Request strobes decode straight from state so the RAM sees them in the same cycle.
  assign inst_req     = (state_q == S_FETCH);
  assign ir_en        = (state_q == S_FETCH) & mem_ready;
  assign data_req     = (state_q == S_MEM);
  assign data_we      = (state_q == S_MEM) & is_store;
  assign reg_write_en = (state_q == S_WB);

  assign pc         = pc_q;
  assign instret    = instret_q;
  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;
  assign state      = state_q;

endmodule

// File: tb/tb_riscv_ctrl.sv
// Directed self-checking bench for riscv_ctrl (TIMEOUT=4, RESET_PC=0).
module tb_riscv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        invalid_i, is_load, is_store, branch_taken, mem_ready;
  logic [31:0] branch_target;
  logic [31:0] pc, instret;
  logic        inst_req, ir_en, data_req, data_we, reg_write_en, trap;
  logic [1:0]  trap_cause;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  riscv_ctrl #(.RESET_PC(32'h0000_0000), .TIMEOUT(8'd4)) dut (
    .clk(clk), .rst_n(rst_n), .invalid_i(invalid_i), .is_load(is_load),
    .is_store(is_store), .branch_taken(branch_taken), .branch_target(branch_target),
    .mem_ready(mem_ready), .pc(pc), .inst_req(inst_req), .ir_en(ir_en),
    .data_req(data_req), .data_we(data_we), .reg_write_en(reg_write_en),
    .trap(trap), .trap_cause(trap_cause), .state(state), .instret(instret)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] reqs();
    return {inst_req, data_req, data_we, ir_en, reg_write_en};
  endfunction

  // ALU op with zero wait: FETCH, DECODE, EXEC, WB, then retire.
  task automatic run_alu(input logic take, input logic [31:0] tgt);
    is_load = 1'b0; is_store = 1'b0; invalid_i = 1'b0; mem_ready = 1'b1;
    branch_taken = take; branch_target = tgt;
    #1;
    check("alu_fetch", 32'(state), 32'd0);
    step(); check("alu_decode", 32'(state), 32'd1);
    step(); check("alu_exec", 32'(state), 32'd2);
    step(); check("alu_wb", 32'(state), 32'd4);
    check("alu_wb_rwe", 32'(reg_write_en), 32'd1);
    step();
  endtask

  initial begin
    rst_n = 1'b0; invalid_i = 1'b0; is_load = 1'b0; is_store = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0; mem_ready = 1'b0;
    step(); step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instret", instret, 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_cause", 32'(trap_cause), 32'd0);

    rst_n = 1'b1;
    #1;
    check("first_inst_req", 32'(inst_req), 32'd1);

    // Plain ALU op
    run_alu(1'b0, 32'h0);
    check("alu_ret_state", 32'(state), 32'd0);
    check("alu_ret_pc", pc, 32'h4);
    check("alu_ret_instret", instret, 32'd1);
    check("alu_ret_rwe", 32'(reg_write_en), 32'd0);

    // Load with 3 wait cycles in MEM
    is_load = 1'b1; mem_ready = 1'b1; #1;
    check("ld_ir_en", 32'(ir_en), 32'd1);
    step(); check("ld_decode", 32'(state), 32'd1);
    check("ld_decode_ir_en", 32'(ir_en), 32'd0);
    mem_ready = 1'b0;
    step(); check("ld_exec", 32'(state), 32'd2);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("ld_mem_state", 32'(state), 32'd3);
      check("ld_mem_reqs", 32'(reqs()), 32'b01000);
      step();
    end
    mem_ready = 1'b1; #1;
    check("ld_mem4_state", 32'(state), 32'd3);
    step(); check("ld_wb", 32'(state), 32'd4);
    check("ld_wb_rwe", 32'(reg_write_en), 32'd1);
    step(); check("ld_ret_state", 32'(state), 32'd0);
    check("ld_ret_pc", pc, 32'h8);
    check("ld_ret_instret", instret, 32'd2);
    is_load = 1'b0;

    // Store with aligned taken branch
    is_store = 1'b1; mem_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
    step(); step(); step();
    check("st_mem_state", 32'(state), 32'd3);
    check("st_mem_reqs", 32'(reqs()), 32'b01100);
    step();
    check("st_ret_state", 32'(state), 32'd0);
    check("st_ret_pc", pc, 32'h100);
    check("st_ret_instret", instret, 32'd3);

    // PC wrap, then misaligned branch target
    run_alu(1'b1, 32'hFFFF_FFFC);
    check("wrap_pre_pc", pc, 32'hFFFF_FFFC);
    run_alu(1'b0, 32'h0);
    check("wrap_pc", pc, 32'h0);
    check("wrap_instret", instret, 32'd5);
    run_alu(1'b1, 32'h102);
    check("mis_state", 32'(state), 32'd7);
    check("mis_trap", 32'(trap), 32'd1);
    check("mis_cause", 32'(trap_cause), 32'd3);
    check("mis_pc", pc, 32'h0);
    check("mis_instret", instret, 32'd5);

    // Asynchronous reset out of TRAP
    rst_n = 1'b0; #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_trap", 32'(trap), 32'd0);
    check("arst_cause", 32'(trap_cause), 32'd0);
    check("arst_instret", instret, 32'd0);
    step();
    rst_n = 1'b1; branch_taken = 1'b0; #1;
    check("arst_inst_req", 32'(inst_req), 32'd1);

    // Illegal instruction
    run_alu(1'b0, 32'h0);
    check("ill_pre_pc", pc, 32'h4);
    mem_ready = 1'b1;
    step();
    invalid_i = 1'b1;
    step();
    check("ill_state", 32'(state), 32'd7);
    check("ill_trap", 32'(trap), 32'd1);
    check("ill_cause", 32'(trap_cause), 32'd1);
    invalid_i = 1'b0; is_store = 1'b1;
    for (int i = 0; i < 100; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      check("ill_reqs", 32'(reqs()), 32'd0);
      step();
    end
    check("ill_hold_state", 32'(state), 32'd7);
    check("ill_hold_cause", 32'(trap_cause), 32'd1);
    check("ill_hold_pc", pc, 32'h4);
    rst_n = 1'b0;
    step();
    check("ill_rst_pc", pc, 32'h0);
    rst_n = 1'b1; is_store = 1'b0;

    // FETCH timeout
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_fetch_state", 32'(state), 32'd0);
      check("to_inst_req", 32'(inst_req), 32'd1);
      step();
    end
    check("to_state", 32'(state), 32'd7);
    check("to_trap", 32'(trap), 32'd1);
    check("to_cause", 32'(trap_cause), 32'd2);
    check("to_reqs", 32'(reqs()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
